gray_seq_monitor: RTL and testbench
===================================

GRAY_SEQ_MONITOR -- requirements
Module: gray_seq_monitor

Interface
REQ-001 SHALL have parameter WRAP_W, default 8, width of the wrap counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk edge only.
REQ-004 SHALL have port en  input  1  sample enable; g is evaluated only in cycles where en=1.
REQ-005 SHALL have port g  input  2  gray code from upstream 2-bit gray counter (legal order 00,01,11,10,00).
REQ-006 SHALL have port clr_err  input  1  clears ERROR state back to IDLE.
REQ-007 SHALL have port bin  output  2  registered binary decode of last accepted code.
REQ-008 SHALL have port step  output  1  one-cycle pulse, legal forward step accepted.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse, accepted step 10->00.
REQ-010 SHALL have port wrap_cnt  output  WRAP_W  count of wraps, modulo 2^WRAP_W.
REQ-011 SHALL have port locked  output  1  high while FSM in LOCKED.
REQ-012 SHALL have port err  output  1  high while FSM in ERROR.

Function
REQ-013 SHALL implement FSM with states IDLE, LOCKED, ERROR; all outputs registered, updated on the clk edge that samples en=1 (visible the cycle after).
REQ-014 SHALL decode bin[1]=g[1], bin[0]=g[1]^g[0] (00->0, 01->1, 11->2, 10->3).
REQ-015 IDLE, en=1: SHALL capture g as reference prev, load bin with decode of g, go LOCKED; step=0, wrap=0.
REQ-016 LOCKED, en=1, g = successor(prev): SHALL set prev=g, update bin, pulse step for exactly one cycle.
REQ-017 LOCKED, en=1, prev=10 and g=00: SHALL additionally pulse wrap and increment wrap_cnt, rolling over from 2^WRAP_W-1 to 0.
REQ-018 LOCKED, en=1, g = prev: behaviour per REQ-027/REQ-028.
REQ-019 LOCKED, en=1, any other g (backward step or two-bit change): SHALL go ERROR; bin, prev, wrap_cnt hold; no step/wrap pulse.
REQ-020 ERROR: SHALL ignore en and g; err=1; bin and wrap_cnt frozen.
REQ-021 ERROR, clr_err=1: SHALL go IDLE next cycle, wrap_cnt retained; clr_err wins over simultaneous en=1 (sample discarded).
REQ-022 clr_err in IDLE or LOCKED SHALL have no effect.
REQ-023 en=0 in any state: SHALL hold state, bin, wrap_cnt; step=wrap=0.

Reset
REQ-024 rst=1 SHALL override en and clr_err and force next state IDLE, regardless of current state or pending event.
REQ-025 Reset values: bin=00, step=0, wrap=0, wrap_cnt=0, locked=0, err=0, prev=00.
REQ-026 First accepted sample after reset release SHALL only resynchronize (REQ-015), never raise err.

Configuration
REQ-027 With macro GRAY_SEQ_MON_STALL_EN defined: g=prev in LOCKED SHALL be a legal hold (no state change, no pulses).
REQ-028 Without GRAY_SEQ_MON_STALL_EN: g=prev in LOCKED with en=1 SHALL be an error (go ERROR, per REQ-019).

Verification
REQ-029 rst, then en=1 with g=01,11,10,00,01 -> locked=1 after first sample; step pulses 4 times; bin=1,2,3,0,1; wrap pulse once; wrap_cnt=1.
REQ-030 Locked at g=01, en=1 g=10 -> err=1, locked=0, bin stays 1; further g=11 ignored; clr_err=1 -> IDLE; next g=11 -> locked, bin=2, err=0.
REQ-031 Locked at g=11, en=1 g=11: with GRAY_SEQ_MON_STALL_EN -> no pulse, locked stays 1; without -> err=1.
REQ-032 WRAP_W=2, drive 4 full cycles 00..10 -> wrap pulses 4 times; wrap_cnt goes 1,2,3,0.
REQ-033 In ERROR, assert clr_err and en together with g=01 -> IDLE, locked=0, bin unchanged; rst mid-LOCKED with en=1 legal step -> all outputs at reset values, no step pulse.

Source files
------------

// File: rtl/gray_seq_monitor.sv
// ============================================================================
// Module   : gray_seq_monitor
// Brief    : Tracks a 2-bit gray counter, decodes it to binary, flags legal
//            steps and wraps, and locks into ERROR on an illegal transition.
//            Optional macro GRAY_SEQ_MON_STALL_EN makes a repeated code a
//            legal hold instead of an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_seq_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        g,
  input  logic              clr_err,
  output logic [1:0]        bin,
  output logic              step,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              locked,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        bin_q, bin_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

  function automatic logic [1:0] gray_to_bin(input logic [1:0] code);
    return {code[1], code[1] ^ code[0]};
  endfunction

  function automatic logic [1:0] gray_succ(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    bin_d      = bin_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          prev_d  = g;
          bin_d   = gray_to_bin(g);
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (en) begin
          if (g == gray_succ(prev_q)) begin
            prev_d = g;
            bin_d  = gray_to_bin(g);
            step_d = 1'b1;
            if (prev_q == 2'b10) begin
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
          end else if (g == prev_q) begin
`ifdef GRAY_SEQ_MON_STALL_EN
            state_d = S_LOCKED;
`else
            state_d = S_ERROR;
`endif
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        // en and g are deliberately ignored here; only clr_err leaves ERROR
        if (clr_err) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d = (state_d == S_LOCKED);
    err_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_q     <= 2'b00;
      bin_q      <= 2'b00;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      bin_q      <= bin_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign bin      = bin_q;
  assign step     = step_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_seq_monitor.sv
// ============================================================================
// Module   : tb_gray_seq_monitor
// Brief    : Directed scoreboard bench for gray_seq_monitor (WRAP_W=8 and 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_seq_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] g;
  logic       clr_err;

  logic [1:0] bin_a, bin_b;
  logic       step_a, step_b, wrap_a, wrap_b, locked_a, locked_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  gray_seq_monitor #(.WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .g(g), .clr_err(clr_err),
    .bin(bin_a), .step(step_a), .wrap(wrap_a), .wrap_cnt(cnt_a),
    .locked(locked_a), .err(err_a)
  );

  gray_seq_monitor #(.WRAP_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .en(en), .g(g), .clr_err(clr_err),
    .bin(bin_b), .step(step_b), .wrap(wrap_b), .wrap_cnt(cnt_b),
    .locked(locked_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] bin;
    logic       step;
    logic       wrap;
    logic [7:0] cnt;
    logic       locked;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation, compare both DUTs.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [1:0] cnt2;
      e = exp_q.pop_front();
      cnt2 = e.cnt[1:0];
      check({e.name, ".bin"},    {6'd0, bin_a},    {6'd0, e.bin});
      check({e.name, ".step"},   {7'd0, step_a},   {7'd0, e.step});
      check({e.name, ".wrap"},   {7'd0, wrap_a},   {7'd0, e.wrap});
      check({e.name, ".cnt"},    cnt_a,            e.cnt);
      check({e.name, ".locked"}, {7'd0, locked_a}, {7'd0, e.locked});
      check({e.name, ".err"},    {7'd0, err_a},    {7'd0, e.err});
      check({e.name, ".w2.bin"},  {6'd0, bin_b},   {6'd0, e.bin});
      check({e.name, ".w2.wrap"}, {7'd0, wrap_b},  {7'd0, e.wrap});
      check({e.name, ".w2.cnt"},  {6'd0, cnt_b},   {6'd0, cnt2});
      check({e.name, ".w2.state"}, {6'd0, locked_b, err_b}, {6'd0, e.locked, e.err});
    end
  end

  // Drive one cycle of inputs (called at negedge) and queue the outputs the
  // registers must show after the following rising edge.
  task automatic v(input logic r, input logic e_in, input logic [1:0] gg, input logic c,
                   input logic [1:0] xbin, input logic xstep, input logic xwrap,
                   input logic [7:0] xcnt, input logic xlock, input logic xerr,
                   input string nm);
    exp_t x;
    rst = r; en = e_in; g = gg; clr_err = c;
    @(posedge clk);
    x.bin = xbin; x.step = xstep; x.wrap = xwrap; x.cnt = xcnt;
    x.locked = xlock; x.err = xerr; x.name = nm;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; g = 2'b00; clr_err = 1'b0;
    @(negedge clk);
    //  rst en  g     clr  bin  stp wrp cnt lck err
    v(1, 0, 2'b00, 0, 2'd0, 0, 0, 8'd0, 0, 0, "reset0");
    v(1, 1, 2'b10, 1, 2'd0, 0, 0, 8'd0, 0, 0, "reset1");
    // legal forward sequence with one wrap
    v(0, 1, 2'b01, 0, 2'd1, 0, 0, 8'd0, 1, 0, "sync01");
    v(0, 1, 2'b11, 0, 2'd2, 1, 0, 8'd0, 1, 0, "step11");
    v(0, 1, 2'b10, 0, 2'd3, 1, 0, 8'd0, 1, 0, "step10");
    v(0, 1, 2'b00, 0, 2'd0, 1, 1, 8'd1, 1, 0, "wrap00");
    v(0, 1, 2'b01, 0, 2'd1, 1, 0, 8'd1, 1, 0, "step01");
    v(0, 0, 2'b10, 0, 2'd1, 0, 0, 8'd1, 1, 0, "en0hold");
    v(0, 0, 2'b10, 1, 2'd1, 0, 0, 8'd1, 1, 0, "clrlocked");
    // illegal two-bit jump 01->10, error freeze, clear, resync
    v(0, 1, 2'b10, 0, 2'd1, 0, 0, 8'd1, 0, 1, "jump");
    v(0, 1, 2'b11, 0, 2'd1, 0, 0, 8'd1, 0, 1, "errignore");
    v(0, 0, 2'b11, 1, 2'd1, 0, 0, 8'd1, 0, 0, "errclr");
    v(0, 1, 2'b11, 0, 2'd2, 0, 0, 8'd1, 1, 0, "resync11");
    // repeated code
`ifdef GRAY_SEQ_MON_STALL_EN
    v(0, 1, 2'b11, 0, 2'd2, 0, 0, 8'd1, 1, 0, "stall");
`else
    v(0, 1, 2'b11, 0, 2'd2, 0, 0, 8'd1, 0, 1, "stall");
`endif
    v(1, 0, 2'b00, 0, 2'd0, 0, 0, 8'd0, 0, 0, "reset2");
    // backward step into ERROR, then clr_err together with en
    v(0, 1, 2'b00, 0, 2'd0, 0, 0, 8'd0, 1, 0, "sync00");
    v(0, 1, 2'b01, 0, 2'd1, 1, 0, 8'd0, 1, 0, "fwd01");
    v(0, 1, 2'b00, 0, 2'd1, 0, 0, 8'd0, 0, 1, "backward");
    v(0, 1, 2'b01, 1, 2'd1, 0, 0, 8'd0, 0, 0, "clrwins");
    v(0, 1, 2'b11, 0, 2'd2, 0, 0, 8'd0, 1, 0, "sync11");
    // reset during a legal step suppresses the pulse
    v(1, 1, 2'b10, 0, 2'd0, 0, 0, 8'd0, 0, 0, "rstmid");
    v(0, 1, 2'b10, 0, 2'd3, 0, 0, 8'd0, 1, 0, "sync10");
    // four wraps: WRAP_W=2 instance rolls 1,2,3,0
    v(0, 1, 2'b00, 0, 2'd0, 1, 1, 8'd1, 1, 0, "cyc1wrap");
    for (int c = 2; c <= 4; c++) begin
      v(0, 1, 2'b01, 0, 2'd1, 1, 0, 8'(c - 1), 1, 0, "cyc01");
      v(0, 1, 2'b11, 0, 2'd2, 1, 0, 8'(c - 1), 1, 0, "cyc11");
      v(0, 1, 2'b10, 0, 2'd3, 1, 0, 8'(c - 1), 1, 0, "cyc10");
      v(0, 1, 2'b00, 0, 2'd0, 1, 1, 8'(c),     1, 0, "cycwrap");
    end
    // two-bit change 00->11
    v(0, 1, 2'b11, 0, 2'd0, 0, 0, 8'd4, 0, 1, "twobit");
    v(0, 0, 2'b00, 1, 2'd0, 0, 0, 8'd4, 0, 0, "finalclr");
    v(1, 0, 2'b00, 0, 2'd0, 0, 0, 8'd0, 0, 0, "reset3");
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
